beam_sum_sequencer: RTL and testbench

BEAM_SUM_SEQUENCER -- requirements
Module: beam_sum_sequencer

---
 rtl/beam_sum_sequencer.sv | 127 ++++++++++++
 tb/tb_beam_sum_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_sum_sequencer.sv
// beam_sum_sequencer: sums N_CH signed channel samples per frame and presents the
// exact frame sum on a valid/ready output, flagging framing violations on frame_err.
`default_nettype none

module beam_sum_sequencer #(
  parameter int N_CH  = 8,
  parameter int IN_W  = 19,
  parameter int OUT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic signed [OUT_W-1:0]  acc;
  logic signed [OUT_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     err_nxt;
  logic                     load_sum;
  logic signed [IN_W-1:0]   in_signed;
  logic signed [OUT_W-1:0]  in_sext;
  logic                     beat;

  // Size cast of a signed operand sign-extends, and is also legal when OUT_W == IN_W.
  assign in_signed = in_data;
  assign in_sext   = OUT_W'(in_signed);
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
      if (load_sum) begin
        out_sum <= acc_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    load_sum  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (beat) begin
          if (in_first) begin
            acc_nxt = in_sext;
            cnt_nxt = CNT_ONE;
            if (CNT_ONE == CNT_LAST) begin
              state_nxt = HOLD;
              load_sum  = 1'b1;
            end else begin
              state_nxt = ACCUM;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (beat) begin
          if (in_first) begin
            // Restart: the partial frame is abandoned and this beat opens a new one.
            err_nxt = 1'b1;
            acc_nxt = in_sext;
            cnt_nxt = CNT_ONE;
          end else begin
            acc_nxt = acc + in_sext;
            cnt_nxt = cnt + CNT_ONE;
            if (cnt_nxt == CNT_LAST) begin
              state_nxt = HOLD;
              load_sum  = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_beam_sum_sequencer.sv
// Self-checking bench for beam_sum_sequencer: directed scenarios plus randomized
// traffic checked against a queue-based frame model.
`default_nettype none

module tb_beam_sum_sequencer;

  localparam int N_CH  = 8;
  localparam int IN_W  = 19;
  localparam int OUT_W = 22;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_first;
  logic             in_ready;
  logic [OUT_W-1:0] out_sum;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             busy;

  int vectors;
  int miscompares;

  beam_sum_sequencer #(
    .N_CH  (N_CH),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the active edge.
  task automatic tick(input bit v, input bit f, input int d, input bit ordy);
    in_valid  = v;
    in_first  = f;
    in_data   = IN_W'(d);
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || out_sum !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b busy=%b err=%b sum=%0d expected all 0",
               out_valid, busy, frame_err, out_sum);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < N_CH; k++) begin
      tick(1'b1, k == 0, 1, 1'b1);
      if (k == N_CH - 2) begin
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_early: got valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== OUT_W'(8)) begin
      miscompares++;
      $display("FAIL basic_sum: got valid=%b sum=%0d expected valid=1 sum=8", out_valid, $signed(out_sum));
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold_ready: got %b expected 0", in_ready);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== OUT_W'(8)) begin
      miscompares++;
      $display("FAIL basic_after: got valid=%b busy=%b sum=%0d expected valid=0 busy=0 sum=8",
               out_valid, busy, $signed(out_sum));
    end
  endtask

  task automatic test_extremes();
    for (int k = 0; k < N_CH; k++) tick(1'b1, k == 0, -262144, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 22'h200000) begin
      miscompares++;
      $display("FAIL extreme_neg: got valid=%b sum=%h expected valid=1 sum=200000", out_valid, out_sum);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < N_CH; k++) tick(1'b1, k == 0, 262143, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 22'h1FFFF8) begin
      miscompares++;
      $display("FAIL extreme_pos: got valid=%b sum=%h expected valid=1 sum=1ffff8", out_valid, out_sum);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N_CH; k++) tick(1'b1, k == 0, 5, 1'b0);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== OUT_W'(40) || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got valid=%b sum=%0d ready=%b expected valid=1 sum=40 ready=0",
                 c, out_valid, $signed(out_sum), in_ready);
      end
      if (c < 4) tick(1'b1, 1'b1, 7, 1'b0);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== OUT_W'(40)) begin
      miscompares++;
      $display("FAIL hold_release: got valid=%b busy=%b sum=%0d expected valid=0 busy=0 sum=40",
               out_valid, busy, $signed(out_sum));
    end
  endtask

  task automatic test_restart();
    tick(1'b1, 1'b1, 100, 1'b1);
    tick(1'b1, 1'b0, 200, 1'b1);
    tick(1'b1, 1'b0, 300, 1'b1);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_pre_err: got %b expected 0", frame_err);
    end
    tick(1'b1, 1'b1, -50, 1'b1);
    vectors++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_err: got err=%b busy=%b expected err=1 busy=1", frame_err, busy);
    end
    for (int k = 0; k < N_CH - 1; k++) begin
      tick(1'b1, 1'b0, 2, 1'b1);
      if (k == 0) begin
        vectors++;
        if (frame_err !== 1'b0) begin
          miscompares++;
          $display("FAIL restart_err_width: got %b expected 0", frame_err);
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== OUT_W'(-36)) begin
      miscompares++;
      $display("FAIL restart_sum: got valid=%b sum=%0d expected valid=1 sum=-36", out_valid, $signed(out_sum));
    end
    tick(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_idle_err();
    tick(1'b1, 1'b0, 9, 1'b1);
    vectors++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_err: got err=%b busy=%b valid=%b expected err=1 busy=0 valid=0",
               frame_err, busy, out_valid);
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    vectors++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_err_clear: got err=%b valid=%b expected 0 0", frame_err, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 5; k++) tick(1'b1, k == 0, 7, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || out_sum !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got valid=%b busy=%b err=%b sum=%0d expected all 0",
               out_valid, busy, frame_err, out_sum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < N_CH; k++) tick(1'b1, k == 0, 3, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== OUT_W'(24)) begin
      miscompares++;
      $display("FAIL midreset_sum: got valid=%b sum=%0d expected valid=1 sum=24", out_valid, $signed(out_sum));
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0) begin
      miscompares++;
      $display("FAIL hold_reset: got valid=%b busy=%b sum=%0d expected 0 0 0", out_valid, busy, out_sum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int   frame_q[$];
    bit   m_hold;
    int   m_sum;
    bit   m_err;
    bit   v;
    bit   f;
    bit   ordy;
    int   d;
    int   s;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_hold = 1'b0;
    m_sum  = 0;
    frame_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      f    = (frame_q.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = $urandom_range(0, (1 << IN_W) - 1) - (1 << (IN_W - 1));
      vectors++;
      if (in_ready !== !m_hold) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, in_ready, !m_hold);
      end
      m_err = 1'b0;
      if (m_hold) begin
        if (ordy) m_hold = 1'b0;
      end else if (v) begin
        if (f) begin
          if (frame_q.size() > 0) m_err = 1'b1;
          frame_q.delete();
          frame_q.push_back(d);
        end else if (frame_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          frame_q.push_back(d);
        end
        if (frame_q.size() == N_CH) begin
          s = 0;
          foreach (frame_q[i]) s += frame_q[i];
          m_sum  = s;
          m_hold = 1'b1;
          frame_q.delete();
        end
      end
      tick(v, f, d, ordy);
      vectors++;
      if (out_valid !== m_hold || frame_err !== m_err) begin
        miscompares++;
        $display("FAIL rand_flags[%0d]: got valid=%b err=%b expected valid=%b err=%b",
                 cyc, out_valid, frame_err, m_hold, m_err);
      end
      vectors++;
      if (busy !== (m_hold || frame_q.size() > 0) || out_sum !== OUT_W'(m_sum)) begin
        miscompares++;
        $display("FAIL rand_sum[%0d]: got busy=%b sum=%0d expected busy=%b sum=%0d",
                 cyc, busy, $signed(out_sum), (m_hold || frame_q.size() > 0), m_sum);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_first    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_restart();
    test_idle_err();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
